// File: rtl/xdma_meta_tracker_if.sv
// Meta push handshake between the request frontend and the tracker.
// Carries DMA ID and beat length alongside valid/ready.
interface xdma_meta_tracker_if #(
   parameter int IdWidth  = 8,
   parameter int LenWidth = 16
);
   logic                meta_valid_i;
   logic                meta_ready_o;
   logic [IdWidth-1:0]  meta_id_i;
   logic [LenWidth-1:0] meta_len_i;

   modport master (
      output meta_valid_i,
      output meta_id_i,
      output meta_len_i,
      input  meta_ready_o
   );

   modport slave (
      input  meta_valid_i,
      input  meta_id_i,
      input  meta_len_i,
      output meta_ready_o
   );
endinterface

// File: rtl/xdma_meta_tracker.sv
// Multi-outstanding AXI W meta tracker: counts beats against the oldest meta.
// Define XDMA_META_TRACKER_STATS_EN to add completion/beat statistics counters.
module xdma_meta_tracker #(
   parameter  int IdWidth  = 8,
   parameter  int LenWidth = 16,
   parameter  int Depth    = 4,
   localparam int CntWidth = $clog2(Depth) + 1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   xdma_meta_tracker_if.slave  meta,
   input  logic                write_happening_i,
   output logic                done_o,
   output logic [IdWidth-1:0]  done_id_o,
   output logic [IdWidth-1:0]  cur_dma_id_o,
   output logic [LenWidth-1:0] cur_beat_o,
   output logic                busy_o,
   output logic [CntWidth-1:0] occupancy_o,
`ifdef XDMA_META_TRACKER_STATS_EN
   output logic [31:0]         completed_cnt_o,
   output logic [31:0]         beat_cnt_o,
`endif
   output logic                unexpected_beat_o
);

   localparam int PtrW = $clog2(Depth);

   logic [IdWidth-1:0]  id_q  [Depth];
   logic [LenWidth-1:0] len_q [Depth];
   logic [PtrW-1:0]     rd_ptr;
   logic [PtrW-1:0]     wr_ptr;
   logic [CntWidth-1:0] count;
   logic [LenWidth-1:0] beat_q;
   logic                err_q;

   logic                busy;
   logic                full;
   logic                push;
   logic                done;
   logic                beat_ok;
   logic                stray;
   logic [IdWidth-1:0]  head_id;
   logic [LenWidth-1:0] head_len;

   assign busy     = (count != '0);
   assign full     = (count == CntWidth'(Depth));
   assign push     = meta.meta_valid_i && !full;
   assign head_id  = id_q[rd_ptr];
   assign head_len = len_q[rd_ptr];
   assign beat_ok  = busy && write_happening_i;
   assign stray    = !busy && write_happening_i;

   // Zero-length heads retire immediately and swallow any beat seen that cycle.
   assign done = busy && ((head_len == '0) ||
                 (write_happening_i && beat_q == head_len - LenWidth'(1)));

   assign meta.meta_ready_o = !full;
   assign done_o            = done;
   assign done_id_o         = done ? head_id : '0;
   assign cur_dma_id_o      = busy ? head_id : '0;
   assign cur_beat_o        = beat_q;
   assign busy_o            = busy;
   assign occupancy_o       = count;
   assign unexpected_beat_o = err_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         beat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (push) begin
            id_q[wr_ptr]  <= meta.meta_id_i;
            len_q[wr_ptr] <= meta.meta_len_i;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (done) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, done})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (done) begin
            beat_q <= '0;
         end else if (beat_ok) begin
            beat_q <= beat_q + 1'b1;
         end
         if (stray) begin
            err_q <= 1'b1;
         end
      end
   end

`ifdef XDMA_META_TRACKER_STATS_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         completed_cnt_o <= '0;
         beat_cnt_o      <= '0;
      end else begin
         if (done) begin
            completed_cnt_o <= completed_cnt_o + 32'd1;
         end
         if (beat_ok) begin
            beat_cnt_o <= beat_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_xdma_meta_tracker.sv
// Self-checking bench for xdma_meta_tracker: directed scenarios plus
// randomized traffic against a queue-based reference model.
module tb_xdma_meta_tracker;

   typedef struct {
      logic [7:0]  id;
      logic [15:0] len;
   } meta_t;

   logic        clk;
   logic        rst;
   logic        wh;
   logic        done;
   logic [7:0]  done_id;
   logic [7:0]  cur_id;
   logic [15:0] cur_beat;
   logic        busy;
   logic [2:0]  occ;
   logic        unexp;
`ifdef XDMA_META_TRACKER_STATS_EN
   logic [31:0] comp_cnt;
   logic [31:0] beat_cnt;
`endif

   int pass_cnt = 0;
   int total    = 0;

   meta_t       mq[$];
   int          mbeat;
   bit          merr;
   int unsigned mcomp;
   int unsigned mbeats;

   xdma_meta_tracker_if #(.IdWidth(8), .LenWidth(16)) m ();

   xdma_meta_tracker #(.IdWidth(8), .LenWidth(16), .Depth(4)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .meta              (m),
      .write_happening_i (wh),
      .done_o            (done),
      .done_id_o         (done_id),
      .cur_dma_id_o      (cur_id),
      .cur_beat_o        (cur_beat),
      .busy_o            (busy),
      .occupancy_o       (occ),
`ifdef XDMA_META_TRACKER_STATS_EN
      .completed_cnt_o   (comp_cnt),
      .beat_cnt_o        (beat_cnt),
`endif
      .unexpected_beat_o (unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit exp_done();
      if (mq.size() == 0) return 1'b0;
      if (mq[0].len == 0) return 1'b1;
      return wh && (mbeat == int'(mq[0].len) - 1);
   endfunction

   function automatic logic [7:0] exp_head();
      if (mq.size() == 0) return 8'd0;
      return mq[0].id;
   endfunction

   // Advance one clock and apply the same edge to the reference model.
   task automatic step();
      bit b;
      bit p;
      bit d;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mbeat  = 0;
         merr   = 0;
         mcomp  = 0;
         mbeats = 0;
      end else begin
         b = (mq.size() != 0);
         p = m.meta_valid_i && (mq.size() < 4);
         d = exp_done();
         if (b && wh) begin
            mbeat++;
            mbeats++;
         end
         if (!b && wh) merr = 1;
         if (d) begin
            void'(mq.pop_front());
            mbeat = 0;
            mcomp++;
         end
         if (p) mq.push_back('{m.meta_id_i, m.meta_len_i});
      end
      @(negedge clk);
   endtask

   task automatic push_one(input logic [7:0] id, input logic [15:0] len);
      m.meta_valid_i = 1'b1;
      m.meta_id_i    = id;
      m.meta_len_i   = len;
      step();
      m.meta_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wh  = 1'b0;
      m.meta_valid_i = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++;
      if ({m.meta_ready_o, done, done_id, cur_id, cur_beat, busy, occ, unexp}
          !== {1'b1, 1'b0, 8'd0, 8'd0, 16'd0, 1'b0, 3'd0, 1'b0})
         $display("FAIL reset_outputs got rdy=%b done=%b busy=%b occ=%0d unexp=%b beat=%0d want rdy=1 rest 0",
                  m.meta_ready_o, done, busy, occ, unexp, cur_beat);
      else pass_cnt++;
   endtask

   task automatic test_single();
      push_one(8'd5, 16'd4);
      for (int k = 0; k < 4; k++) begin
         wh = 1'b1;
         #1;
         total++;
         if (cur_beat !== 16'(k))
            $display("FAIL single_beat%0d got %0d want %0d", k, cur_beat, k);
         else pass_cnt++;
         total++;
         if (done !== (k == 3))
            $display("FAIL single_done%0d got %b want %b", k, done, k == 3);
         else pass_cnt++;
         if (k == 3) begin
            total++;
            if (done_id !== 8'd5)
               $display("FAIL single_done_id got %0d want 5", done_id);
            else pass_cnt++;
         end
         step();
      end
      wh = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) $display("FAIL single_idle busy got %b want 0", busy);
      else pass_cnt++;
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 1; i <= 4; i++) push_one(8'(i), 16'd2);
      m.meta_valid_i = 1'b1;
      m.meta_id_i    = 8'd9;
      m.meta_len_i   = 16'd2;
      #1;
      total++;
      if (m.meta_ready_o !== 1'b0 || occ !== 3'd4)
         $display("FAIL fill_full got rdy=%b occ=%0d want rdy=0 occ=4", m.meta_ready_o, occ);
      else pass_cnt++;
      step();
      m.meta_valid_i = 1'b0;
      total++;
      if (occ !== 3'd4) $display("FAIL fill_stall got occ=%0d want 4", occ);
      else pass_cnt++;
      for (int k = 0; k < 8; k++) begin
         wh = 1'b1;
         #1;
         total++;
         if (done !== (k % 2 == 1) || (done && done_id !== 8'(k / 2 + 1)))
            $display("FAIL fill_beat%0d got done=%b id=%0d want done=%b id=%0d",
                     k, done, done_id, k % 2 == 1, k / 2 + 1);
         else pass_cnt++;
         step();
      end
      wh = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0) $display("FAIL fill_drain busy got %b want 0", busy);
      else pass_cnt++;
`ifdef XDMA_META_TRACKER_STATS_EN
      total++;
      if (comp_cnt !== 32'd4 || beat_cnt !== 32'd8)
         $display("FAIL fill_stats got comp=%0d beats=%0d want 4 8", comp_cnt, beat_cnt);
      else pass_cnt++;
`endif
   endtask

   task automatic test_zero_len();
      push_one(8'd7, 16'd0);
      m.meta_valid_i = 1'b1;
      m.meta_id_i    = 8'd8;
      m.meta_len_i   = 16'd1;
      #1;
      total++;
      if (done !== 1'b1 || done_id !== 8'd7)
         $display("FAIL zero_done got done=%b id=%0d want 1 7", done, done_id);
      else pass_cnt++;
      step();
      m.meta_valid_i = 1'b0;
      #1;
      total++;
      if (cur_id !== 8'd8 || done !== 1'b0)
         $display("FAIL zero_next got head=%0d done=%b want 8 0", cur_id, done);
      else pass_cnt++;
      wh = 1'b1;
      #1;
      total++;
      if (done !== 1'b1 || done_id !== 8'd8)
         $display("FAIL zero_follow got done=%b id=%0d want 1 8", done, done_id);
      else pass_cnt++;
      step();
      wh = 1'b0;
   endtask

   task automatic test_unexpected();
      wh = 1'b1;
      #1;
      total++;
      if (unexp !== 1'b0) $display("FAIL unexp_pre got %b want 0", unexp);
      else pass_cnt++;
      step();
      wh = 1'b0;
      push_one(8'd3, 16'd1);
      total++;
      if (unexp !== 1'b1) $display("FAIL unexp_sticky got %b want 1", unexp);
      else pass_cnt++;
      wh = 1'b1;
      #1;
      total++;
      if (done !== 1'b1 || done_id !== 8'd3)
         $display("FAIL unexp_after got done=%b id=%0d want 1 3", done, done_id);
      else pass_cnt++;
      step();
      wh = 1'b0;
      #1;
      total++;
      if (unexp !== 1'b1 || busy !== 1'b0)
         $display("FAIL unexp_hold got unexp=%b busy=%b want 1 0", unexp, busy);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      push_one(8'd2, 16'd10);
      wh = 1'b1;
      for (int k = 0; k < 6; k++) step();
      #1;
      total++;
      if (cur_beat !== 16'd6) $display("FAIL mid_beats got %0d want 6", cur_beat);
      else pass_cnt++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      wh  = 1'b0;
      #1;
      total++;
      if (occ !== 3'd0 || cur_beat !== 16'd0 || done !== 1'b0 ||
          m.meta_ready_o !== 1'b1 || unexp !== 1'b0)
         $display("FAIL mid_reset got occ=%0d beat=%0d done=%b rdy=%b unexp=%b want 0 0 0 1 0",
                  occ, cur_beat, done, m.meta_ready_o, unexp);
      else pass_cnt++;
`ifdef XDMA_META_TRACKER_STATS_EN
      total++;
      if (comp_cnt !== 32'd0 || beat_cnt !== 32'd0)
         $display("FAIL mid_stats got comp=%0d beats=%0d want 0 0", comp_cnt, beat_cnt);
      else pass_cnt++;
`endif
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         rst            = ($urandom_range(99) == 0);
         m.meta_valid_i = ($urandom_range(99) < 45);
         m.meta_id_i    = 8'($urandom);
         m.meta_len_i   = 16'($urandom_range(4));
         wh             = ($urandom_range(99) < 60);
         #1;
         total++;
         if (done !== exp_done() || done_id !== (exp_done() ? exp_head() : 8'd0) ||
             cur_id !== exp_head() || cur_beat !== 16'(mbeat) ||
             busy !== (mq.size() != 0) || occ !== 3'(mq.size()) ||
             m.meta_ready_o !== (mq.size() < 4) || unexp !== merr
`ifdef XDMA_META_TRACKER_STATS_EN
             || comp_cnt !== mcomp || beat_cnt !== mbeats
`endif
            ) begin
            errs++;
            if (errs <= 10)
               $display("FAIL rand_cyc%0d got done=%b id=%0d head=%0d beat=%0d occ=%0d unexp=%b want done=%b head=%0d beat=%0d occ=%0d unexp=%b",
                        c, done, done_id, cur_id, cur_beat, occ, unexp,
                        exp_done(), exp_head(), mbeat, mq.size(), merr);
         end else pass_cnt++;
         step();
      end
      rst = 1'b0;
      wh  = 1'b0;
      m.meta_valid_i = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      wh  = 1'b0;
      m.meta_valid_i = 1'b0;
      m.meta_id_i    = '0;
      m.meta_len_i   = '0;
      mbeat = 0;
      merr  = 0;
      mcomp = 0;
      mbeats = 0;
      @(negedge clk);
      test_reset();
      test_single();
      test_fill();
      test_zero_len();
      test_unexpected();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/xdma_meta_tracker.md
Name: xdma_meta_tracker

Overview:
- Multi-outstanding successor to the single-transfer write meta manager in the xDMA AXI adapter.
- Queues up to Depth write-request metas (DMA ID + beat length) and counts AXI W handshakes against the oldest entry.
- Emits a one-cycle done pulse carrying the finished ID, then retires the entry.
- Sits between the request frontend and the AXI W channel; B responses are not tracked.

Parameters:
- IdWidth, 8, width of dma_id.
- LenWidth, 16, width of dma_length in beats; also the beat-counter width.
- Depth, 4, number of outstanding metas (power of two, >=2).
- CntWidth, $clog2(Depth)+1, occupancy width (derived, not overridable).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- meta_valid_i  in  1  push request.
- meta_ready_o  out  1  queue not full.
- meta_id_i  in  IdWidth  DMA ID of the pushed request.
- meta_len_i  in  LenWidth  beat count of the pushed request (0 allowed).
- write_happening_i  in  1  AXI W valid&&ready this cycle.
- done_o  out  1  head request completes this cycle.
- done_id_o  out  IdWidth  ID of the completing request; 0 when done_o=0.
- cur_dma_id_o  out  IdWidth  head ID; 0 when empty.
- cur_beat_o  out  LenWidth  beats already counted for the head.
- busy_o  out  1  occupancy != 0.
- occupancy_o  out  CntWidth  entries held.
- unexpected_beat_o  out  1  sticky error flag.

Behaviour:
- Reset (rst_i=1 at an edge):
  - Clears the queue, beat counter and error flag.
  - All outputs are 0 except meta_ready_o, which is 1.
  - Reset mid-transfer discards all entries without issuing done.
- Push:
  - Occurs when meta_valid_i && meta_ready_o; the entry is visible at the head/occupancy on the next cycle.
  - meta_ready_o = !full, registered-state only.
  - No combinational dependence on pop: a full queue refuses push even in a cycle where it pops.
- Head counting:
  - When busy_o=1 and write_happening_i=1, the beat counter increments.
- Completion:
  - done_o = busy && ((head_len==0) || (write_happening_i && cur_beat_o==head_len-1)).
  - Combinational: done_o is asserted in the same cycle as the final beat.
- Zero-length entry completes the cycle it reaches the head, with no beat required.
  - A beat present in that cycle is charged to the zero-length entry, i.e. consumed and not counted toward the next entry.
- On done_o:
  - The entry pops and the beat counter clears to 0 at the edge.
  - The next entry becomes head the following cycle, so back-to-back completions are possible every cycle.
- Simultaneous push and pop: occupancy is unchanged.
- Unexpected beat: write_happening_i while busy_o=0 (including the cycle a push into an empty queue occurs):
  - The beat is ignored.
  - unexpected_beat_o sets and holds until reset.
- Arithmetic is modulo 2^LenWidth; the maximum length is 2^LenWidth-1, and the counter never wraps within a legal request.
- Pointers wrap modulo Depth; the occupancy range is 0..Depth.

Optional Feature:
- Macro: XDMA_META_TRACKER_STATS_EN.
- When defined:
  - Adds outputs completed_cnt_o [31:0] and beat_cnt_o [31:0].
  - completed_cnt_o counts done_o pulses.
  - beat_cnt_o counts accepted (non-unexpected) beats.
  - Both counters are free-running, wrap at 2^32, and clear on rst_i.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Push {id=5,len=4}, then 4 beats on consecutive cycles:
  - cur_beat_o reads 0,1,2,3.
  - done_o=1 with done_id_o=5 on the 4th beat cycle only.
  - busy_o=0 the next cycle.
- Fill with ids 1..4 (len=2 each):
  - meta_ready_o=0, occupancy_o=4.
  - Push of id 9 is stalled.
  - 8 continuous beats give done pulses on beats 2,4,6,8 with ids 1,2,3,4 in order.
- Push {id=7,len=0} then {id=8,len=1}, no beats:
  - done_o with id 7 the cycle after the push.
  - Id 8 becomes head, and a single beat then completes it.
- Beat while empty:
  - unexpected_beat_o=1 and stays 1.
  - A subsequent {id=3,len=1} still completes correctly on its beat.
- Reset asserted mid-transfer (head len=10 after 6 beats):
  - Next cycle: occupancy_o=0, cur_beat_o=0, no done pulse, meta_ready_o=1.
- With XDMA_META_TRACKER_STATS_EN:
  - After the fill test, completed_cnt_o=4 and beat_cnt_o=8.
  - Both read 0 after reset.
